// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer.
// It runs radix-2 shift-add multiply or restoring divide, one bit per cycle.
// While an op is in flight it stalls the PC. When the result is ready it
// pulses hilo_we for one cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_div,
  input  logic             op_sign,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  typedef struct packed {
    logic             div;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t             st, st_nx;
  op_t                op_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   ma, mb;       // operand magnitudes
  logic               sgn_a, sgn_x; // dividend sign, result sign
  logic [2*WIDTH-1:0] acc;          // mul: {hi, multiplier}; div: {rem, dividend/quotient}

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Magnitudes of the latched operands (identity for unsigned ops)
  always_comb begin
    abs_a = (op_q.sign && op_q.a[WIDTH-1]) ? -op_q.a : op_q.a;
    abs_b = (op_q.sign && op_q.b[WIDTH-1]) ? -op_q.b : op_q.b;
  end

  // One iteration step.
  // mul: add-then-shift-right.
  // div: shift-left, trial subtract, restore on borrow.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
    div_diff = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, mb};
    if (op_q.div) begin
      if (!div_diff[WIDTH+1])
        acc_nx = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nx = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_nx = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the unsigned result
  always_comb begin
    prod_fix = sgn_x ? -acc : acc;
    q_fix    = sgn_x ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = sgn_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Next-state logic and handshake outputs; flush overrides everything
  always_comb begin
    st_nx   = st;
    stall   = 1'b0;
    busy    = 1'b1;
    hilo_we = 1'b0;
    case (st)
      IDLE: begin
        busy  = 1'b0;
        stall = op_valid;
        if (op_valid) st_nx = PREP;
      end
      PREP: begin
        stall = 1'b1;
        st_nx = RUN;
      end
      RUN: begin
        stall = 1'b1;
        if (cnt == CW'(WIDTH-1)) st_nx = FIX;
      end
      FIX: begin
        stall = 1'b1;
        st_nx = DONE;
      end
      DONE: begin
        hilo_we = ~flush;
        st_nx   = IDLE;
      end
      default: begin
        busy  = 1'b0;
        st_nx = IDLE;
      end
    endcase
    if (flush) st_nx = IDLE;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st <= IDLE;
    else        st <= st_nx;
  end

  // Datapath: latch on accept, condition operands, iterate, publish result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      cnt      <= '0;
      ma       <= '0;
      mb       <= '0;
      sgn_a    <= 1'b0;
      sgn_x    <= 1'b0;
      acc      <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (st)
        IDLE: if (op_valid && !flush) begin
          op_q     <= '{div: op_div, sign: op_sign, a: op_a, b: op_b};
          div_zero <= 1'b0;
        end
        PREP: begin
          ma    <= abs_a;
          mb    <= abs_b;
          sgn_a <= op_q.sign & op_q.a[WIDTH-1];
          sgn_x <= op_q.sign & (op_q.a[WIDTH-1] ^ op_q.b[WIDTH-1]);
          acc   <= op_q.div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          cnt   <= '0;
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + CW'(1);
        end
        FIX: if (!flush) begin
          if (op_q.div && op_q.b == '0) begin
            lo_out   <= '1;
            hi_out   <= op_q.a;
            div_zero <= 1'b1;
          end else if (op_q.div) begin
            lo_out <= q_fix;
            hi_out <= r_fix;
          end else begin
            lo_out <= prod_fix[WIDTH-1:0];
            hi_out <= prod_fix[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of ops plus flush/reset/back-to-back sequences.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         op_valid, op_div, op_sign, flush;
  logic [W-1:0] op_a, op_b;
  logic         stall, busy, hilo_we, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_div(op_div),
    .op_sign(op_sign), .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .busy(busy), .hilo_we(hilo_we), .hi_out(hi_out),
    .lo_out(lo_out), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic         div;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Present one op at a negedge, track it to DONE, then verify timing and result
  task automatic run_op(input vec_t v, input int idx);
    int k;
    int stall_cnt;
    bit seen;
    @(negedge clock);
    op_valid = 1'b1; op_div = v.div; op_sign = v.sign; op_a = v.a; op_b = v.b;
    #1 stall_cnt = stall ? 1 : 0;
    k = 0; seen = 0;
    while (!seen && k < 100) begin
      @(negedge clock);
      k++;
      if (k == 3) begin op_a = ~op_a; op_b = op_b ^ 32'h55; end
      if (hilo_we) seen = 1;
      else if (stall) stall_cnt++;
    end
    chk($sformatf("v%0d done_cycle", idx), 64'(k), 64'd35);
    chk($sformatf("v%0d stall_cycles", idx), 64'(stall_cnt), 64'd35);
    chk($sformatf("v%0d stall_in_done", idx), 64'(stall), 64'd0);
    chk($sformatf("v%0d hi", idx), 64'(hi_out), 64'(v.hi));
    chk($sformatf("v%0d lo", idx), 64'(lo_out), 64'(v.lo));
    chk($sformatf("v%0d div_zero", idx), 64'(div_zero), 64'(v.dz));
    op_valid = 1'b0;
    @(negedge clock);
    chk($sformatf("v%0d we_after", idx), 64'(hilo_we), 64'd0);
    chk($sformatf("v%0d busy_after", idx), 64'(busy), 64'd0);
  endtask

  initial begin
    int k, p1, p2;
    logic [W-1:0] hold_hi, hold_lo;

    //              div  sgn  a             b             hi            lo            dz
    vecs[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

    reset = 1'b0; op_valid = 1'b0; op_div = 1'b0; op_sign = 1'b0;
    op_a = '0; op_b = '0; flush = 1'b0;

    // Reset and idle
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    @(negedge clock); reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("idle_stall", 64'(stall), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_we", 64'(hilo_we), 64'd0);
    chk("idle_hi", 64'(hi_out), 64'd0);
    chk("idle_lo", 64'(lo_out), 64'd0);
    chk("idle_dz", 64'(div_zero), 64'd0);

    for (int i = 0; i < 11; i++) run_op(vecs[i], i);

    // Flush at C10: no write, old result held
    hold_hi = hi_out; hold_lo = lo_out;
    @(negedge clock);
    op_valid = 1'b1; op_div = 1'b0; op_sign = 1'b1; op_a = 32'd3; op_b = 32'd5;
    k = 0;
    repeat (10) begin
      @(negedge clock);
      k++;
      if (hilo_we) chk("flush_early_we", 64'(hilo_we), 64'd0);
    end
    chk("flush_busy_c10", 64'(busy), 64'd1);
    flush = 1'b1; op_valid = 1'b0;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_busy_c11", 64'(busy), 64'd0);
    chk("flush_stall_c11", 64'(stall), 64'd0);
    p1 = 0;
    repeat (40) begin
      @(negedge clock);
      if (hilo_we || busy) p1++;
    end
    chk("flush_no_we", 64'(p1), 64'd0);
    chk("flush_hi_held", 64'(hi_out), 64'(hold_hi));
    chk("flush_lo_held", 64'(lo_out), 64'(hold_lo));

    // Flush in IDLE blocks the accept
    op_valid = 1'b1; flush = 1'b1;
    @(negedge clock);
    op_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-RUN
    @(negedge clock);
    op_valid = 1'b1; op_div = 1'b0; op_sign = 1'b0; op_a = 32'hFFFF; op_b = 32'hFFFF;
    repeat (15) @(negedge clock);
    #2 reset = 1'b0; op_valid = 1'b0;
    #1;
    chk("arst_hi", 64'(hi_out), 64'd0);
    chk("arst_lo", 64'(lo_out), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    chk("arst_after_busy", 64'(busy), 64'd0);

    // Back-to-back MULTU: op_valid held across both ops
    op_valid = 1'b1; op_div = 1'b0; op_sign = 1'b0; op_a = 32'd6; op_b = 32'd7;
    k = 0; p1 = -1; p2 = -1;
    while (p2 < 0 && k < 150) begin
      @(negedge clock);
      k++;
      if (hilo_we) begin
        if (p1 < 0) p1 = k; else p2 = k;
        chk("b2b_lo", 64'(lo_out), 64'd42);
        chk("b2b_hi", 64'(hi_out), 64'd0);
      end
    end
    op_valid = 1'b0;
    chk("b2b_first", 64'(p1), 64'd35);
    chk("b2b_gap", 64'(p2 - p1), 64'd36);
    @(negedge clock);
    chk("b2b_we_after", 64'(hilo_we), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
